ifu_pc_gen: RTL

Fetch-stage PC generator and instruction-fetch sequencer, directly upstream of the branch target buffer. It owns the architectural fetch PC, presents it to the BTB for lookup, and issues one instruction-memory request at a time over a valid/ready handshake. It picks the next PC from the BTB prediction or from a backend redirect (`flush_i`). It buffers each returned instruction, together with its PC and the prediction used, until decode accepts it.

---
 rtl/ifu_pc_gen_pkg.sv | 23 ++
 rtl/ifu_next_pc.sv | 33 +++
 rtl/ifu_pc_gen.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/ifu_pc_gen_pkg.sv
// rtl/ifu_pc_gen_pkg.sv - shared fetch-state encoding, reset PC default and alignment helper
package ifu_pc_gen_pkg;

  // Fetch sequencer states; IDLE is only ever visited out of reset.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_WAIT = 3'd2,
    ST_DROP = 3'd3,
    ST_HOLD = 3'd4
  } fetch_state_t;

  localparam logic [31:0] IFU_RESET_PC = 32'h8000_0000;

  // Instruction size in bytes; also the PC alignment granule.
  localparam logic [31:0] INST_ALIGN = 32'd4;

  // Clear the sub-instruction offset bits of a PC.
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return pc & ~(INST_ALIGN - 32'd1);
  endfunction

endpackage

// File: rtl/ifu_next_pc.sv
// rtl/ifu_next_pc.sv - next fetch PC select (BTB prediction vs sequential), prediction via IFU_BTB_PREDICT_EN
module ifu_next_pc
  import ifu_pc_gen_pkg::*;
(
  input  logic [31:0] pc,
  input  logic        btb_pvalid,
  input  logic        btb_ptaken,
  input  logic [31:0] btb_ptarget,
  output logic [31:0] next_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target
);

  logic [31:0] seq_pc;

  // Sequential successor wraps modulo 2^32.
  assign seq_pc = align_pc(pc + INST_ALIGN);

`ifdef IFU_BTB_PREDICT_EN
  assign pred_taken = btb_pvalid && btb_ptaken;
  assign next_pc    = pred_taken ? align_pc(btb_ptarget) : seq_pc;
`else
  // Prediction disabled: BTB inputs are deliberately ignored.
  logic unused_btb;
  assign unused_btb = ^{btb_pvalid, btb_ptaken, btb_ptarget};
  assign pred_taken = 1'b0;
  assign next_pc    = seq_pc;
`endif

  // The target reported downstream is the PC fetch actually moved to.
  assign pred_target = next_pc;

endmodule

// File: rtl/ifu_pc_gen.sv
// rtl/ifu_pc_gen.sv - fetch PC generator and single-outstanding imem sequencer; BTB prediction via IFU_BTB_PREDICT_EN
module ifu_pc_gen
  import ifu_pc_gen_pkg::*;
#(
  parameter logic [31:0] RESET_PC = IFU_RESET_PC
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] btb_pc_o,
  input  logic        btb_pvalid_i,
  input  logic        btb_ptaken_i,
  input  logic [31:0] btb_ptarget_i,
  input  logic        flush_i,
  input  logic [31:0] flush_target_i,
  output logic        req_valid_o,
  input  logic        req_ready_i,
  output logic [31:0] req_addr_o,
  input  logic        rsp_valid_i,
  input  logic [31:0] rsp_data_i,
  output logic        inst_valid_o,
  input  logic        inst_ready_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
  output logic        inst_ptaken_o,
  output logic [31:0] inst_ptarget_o
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  next_pc;
  logic         pred_taken;
  logic [31:0]  pred_target;
  logic         accept;
  logic         capture;

  logic [31:0]  inst_q;
  logic [31:0]  inst_pc_q;
  logic         inst_ptaken_q;
  logic [31:0]  inst_ptarget_q;

  ifu_next_pc u_next_pc (
    .pc          (pc_q),
    .btb_pvalid  (btb_pvalid_i),
    .btb_ptaken  (btb_ptaken_i),
    .btb_ptarget (btb_ptarget_i),
    .next_pc     (next_pc),
    .pred_taken  (pred_taken),
    .pred_target (pred_target)
  );

  // Next-state, next-PC and handshake outputs; flush overrides everything but IDLE.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_valid_o  = 1'b0;
    inst_valid_o = 1'b0;
    accept       = 1'b0;
    capture      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        state_d = ST_REQ;
      end
      ST_REQ: begin
        if (flush_i) begin
          pc_d = align_pc(flush_target_i);
        end else begin
          req_valid_o = 1'b1;
          if (req_ready_i) begin
            accept  = 1'b1;
            pc_d    = next_pc;
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (flush_i) begin
          pc_d    = align_pc(flush_target_i);
          state_d = rsp_valid_i ? ST_REQ : ST_DROP;
        end else if (rsp_valid_i) begin
          capture = 1'b1;
          state_d = ST_HOLD;
        end
      end
      ST_DROP: begin
        // A flush here only retargets the PC; the stale response must still be
        // absorbed before a new request may go out.
        if (flush_i) begin
          pc_d = align_pc(flush_target_i);
        end
        if (rsp_valid_i) begin
          state_d = ST_REQ;
        end
      end
      ST_HOLD: begin
        if (flush_i) begin
          pc_d    = align_pc(flush_target_i);
          state_d = ST_REQ;
        end else begin
          inst_valid_o = 1'b1;
          if (inst_ready_i) begin
            state_d = ST_REQ;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and fetch PC registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      pc_q    <= align_pc(RESET_PC);
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Instruction buffer: PC and prediction latched at request acceptance, data at response.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      inst_q         <= '0;
      inst_pc_q      <= '0;
      inst_ptaken_q  <= 1'b0;
      inst_ptarget_q <= '0;
    end else begin
      if (accept) begin
        inst_pc_q      <= pc_q;
        inst_ptaken_q  <= pred_taken;
        inst_ptarget_q <= pred_target;
      end
      if (capture) begin
        inst_q <= rsp_data_i;
      end
    end
  end

  assign btb_pc_o       = pc_q;
  assign req_addr_o     = pc_q;
  assign inst_o         = inst_q;
  assign inst_pc_o      = inst_pc_q;
  assign inst_ptaken_o  = inst_ptaken_q;
  assign inst_ptarget_o = inst_ptarget_q;

endmodule
